// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- shared types and constants for the pipeline hazard controller.
//   REG_ADDR_WIDTH : default register-index width
//   fwd_sel_t      : E-stage operand source select (regfile / W result / M result)
//   hz_state_t     : multi-cycle op FSM states
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if -- bundle between the pipeline datapath and the
// hazard controller.
//   slave  modport : controller side (stage register info in, controls out)
//   master modport : datapath side
// There is no flow control on this bundle: every signal is valid every cycle
// and the controller answers combinationally within the same cycle.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
  #(parameter int AW = REG_ADDR_WIDTH);

  // D stage
  logic [AW-1:0] rs1D, rs2D;
  // E stage
  logic [AW-1:0] rs1E, rs2E, rdE;
  logic          regWriteE, memReadE, pcSrcE, mcStartE, mcDoneE;
  // M / W stages
  logic [AW-1:0] rdM, rdW;
  logic          regWriteM, regWriteW;
  // controls back to the pipe registers
  logic          stallF, stallD, stallE, flushD, flushE, flushM;
  fwd_sel_t      forwardAE, forwardBE;
  logic          mcBusy, mcErr;

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, regWriteE, memReadE, pcSrcE,
           mcStartE, mcDoneE, rdM, rdW, regWriteM, regWriteW,
    output stallF, stallD, stallE, flushD, flushE, flushM,
           forwardAE, forwardBE, mcBusy, mcErr
  );

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, regWriteE, memReadE, pcSrcE,
           mcStartE, mcDoneE, rdM, rdW, regWriteM, regWriteW,
    input  stallF, stallD, stallE, flushD, flushE, flushM,
           forwardAE, forwardBE, mcBusy, mcErr
  );

endinterface

// File: rtl/hazard_mc_fsm.sv
// hazard_mc_fsm -- tracks a multi-cycle (MUL/DIV) op occupying the E stage.
//   clk, rst  : clock, synchronous active-high reset
//   mcStartE  : op starts in E this cycle
//   pcSrcE    : taken branch in E; a start squashed by it is not entered
//   mcDoneE   : op result valid
//   mcBusy    : FSM is in MC_WAIT
//   mcErr     : sticky timeout flag, cleared only by rst
//   state     : current state, exported for debug/checkers
// Timeout: the counter runs 0..MC_TIMEOUT-1 while waiting, so an op that
// never completes holds E for exactly MC_TIMEOUT cycles. A done arriving on
// the final cycle wins over the timeout.
module hazard_mc_fsm
  import pipeline_pkg::*;
  #(parameter int MC_TIMEOUT = 64)
  (
    input  logic      clk,
    input  logic      rst,
    input  logic      mcStartE,
    input  logic      pcSrcE,
    input  logic      mcDoneE,
    output logic      mcBusy,
    output logic      mcErr,
    output hz_state_t state
  );

  localparam int CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MC_TIMEOUT - 1);

  hz_state_t     state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      mcErr <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mcErr <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = mcErr;
    unique case (state)
      RUN: begin
        if (mcStartE && !pcSrcE) begin
          state_n = MC_WAIT;
          cnt_n   = '0;
        end
      end
      MC_WAIT: begin
        if (mcDoneE) begin
          state_n = RUN;
        end else if (cnt == LAST) begin
          state_n = RUN;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign mcBusy = (state == MC_WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- stall/flush/forward control for a 5-stage pipeline.
//   clk, rst  : clock, synchronous active-high reset
//   hz        : pipeline_hazard_ctrl_if.slave (stage info in, controls out)
//   dbg_state : multi-cycle FSM state for debug/checkers
// Build option HAZARD_FORWARDING_EN:
//   defined   : M/W results forwarded to E operands; only load-use stalls.
//   undefined : forwards tied to regfile; any E/M producer matching a D
//               source stalls F/D and bubbles E. W needs no stall because
//               the regfile is write-first.
// Priority of pipe controls: reset > multi-cycle wait > branch flush > data stall.
// All hazard controls are combinational from the current inputs; only the
// multi-cycle wait comes from registered state.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
  parameter int MC_TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz,
  output pipeline_pkg::hz_state_t dbg_state
);

  // Producer rd (non-zero, write-enabled) matches either source.
  function automatic logic src_hit(input logic [REG_ADDR_WIDTH-1:0] rd,
                                   input logic                      we,
                                   input logic [REG_ADDR_WIDTH-1:0] rs_a,
                                   input logic [REG_ADDR_WIDTH-1:0] rs_b);
    return we && (rd != '0) && ((rd == rs_a) || (rd == rs_b));
  endfunction

  logic mc_busy, mc_err;
  logic lu_hit, raw_hit;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

  hazard_mc_fsm #(.MC_TIMEOUT(MC_TIMEOUT)) u_mc_fsm (
    .clk      (clk),
    .rst      (rst),
    .mcStartE (hz.mcStartE),
    .pcSrcE   (hz.pcSrcE),
    .mcDoneE  (hz.mcDoneE),
    .mcBusy   (mc_busy),
    .mcErr    (mc_err),
    .state    (dbg_state)
  );

  // Load in E whose result a D source needs: data arrives too late to forward.
  assign lu_hit = src_hit(hz.rdE, hz.memReadE, hz.rs1D, hz.rs2D);

`ifdef HAZARD_FORWARDING_EN
  function automatic pipeline_pkg::fwd_sel_t fwd_pick(
      input logic [REG_ADDR_WIDTH-1:0] rs,
      input logic [REG_ADDR_WIDTH-1:0] rd_m, input logic we_m,
      input logic [REG_ADDR_WIDTH-1:0] rd_w, input logic we_w);
    // M is the younger producer, so it wins over W.
    if (src_hit(rd_m, we_m, rs, rs))      return pipeline_pkg::FWD_M;
    else if (src_hit(rd_w, we_w, rs, rs)) return pipeline_pkg::FWD_W;
    else                                  return pipeline_pkg::FWD_RF;
  endfunction

  logic unused_nofwd_inputs;

  assign raw_hit      = 1'b0;
  assign hz.forwardAE = fwd_pick(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
  assign hz.forwardBE = fwd_pick(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
  // regWriteE only matters for the stall-based scheme.
  assign unused_nofwd_inputs = hz.regWriteE;
`else
  logic unused_fwd_inputs;

  assign raw_hit = src_hit(hz.rdE, hz.regWriteE, hz.rs1D, hz.rs2D) ||
                   src_hit(hz.rdM, hz.regWriteM, hz.rs1D, hz.rs2D);
  assign hz.forwardAE = pipeline_pkg::FWD_RF;
  assign hz.forwardBE = pipeline_pkg::FWD_RF;
  // E sources and the W producer are only consulted when forwarding.
  assign unused_fwd_inputs = ^{hz.rs1E, hz.rs2E, hz.rdW, hz.regWriteW};
`endif

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else if (mc_busy) begin
      // Freeze F/D/E around the op and feed bubbles into M.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (hz.pcSrcE) begin
      // Wrong-path instructions in D/E are dropped; no point stalling them.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu_hit || raw_hit) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.stallF = stall_f;
  assign hz.stallD = stall_d;
  assign hz.stallE = stall_e;
  assign hz.flushD = flush_d;
  assign hz.flushE = flush_e;
  assign hz.flushM = flush_m;
  assign hz.mcBusy = mc_busy;
  assign hz.mcErr  = mc_err;

endmodule
